// File: rtl/uart_pkg.sv
// Shared definitions for the uart_top register-bus initiator: register map,
// config-word layout, FSM encoding and the queued command format.
package uart_pkg;
  localparam logic [31:0] UART_REG_CFG  = 32'h0000_0000;
  localparam logic [31:0] UART_REG_DATA = 32'h0000_0004;
  localparam logic [31:0] UART_REG_STAT = 32'h0000_0008;

  // config word field positions
  localparam int CFG_DIV_LSB  = 0;
  localparam int CFG_DIV_MSB  = 15;
  localparam int CFG_F1_LSB   = 16;
  localparam int CFG_F1_MSB   = 20;
  localparam int CFG_F2_LSB   = 21;
  localparam int CFG_F2_MSB   = 24;
  localparam int CFG_PAR_LSB  = 25;
  localparam int CFG_PAR_MSB  = 26;
  localparam int CFG_STOP_LSB = 27;
  localparam int CFG_STOP_MSB = 28;
  localparam int CFG_RXIE_BIT = 29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;
endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally so the
// master can load it on the same edge that pops it.
module uart_cmd_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic          push_ok, pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_reg_master.sv
// Queued initiator for the uart_top four-phase register handshake; one
// transaction in flight, one in-order response per command, per-phase timeout.
module uart_reg_master
  import uart_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        uart_reg_wr_en,
  output logic        uart_reg_rd_en,
  output logic [31:0] uart_reg_addr,
  output logic [31:0] uart_reg_wdata,
  input  logic [31:0] uart_reg_rdata,
  input  logic        uart_ready,
  output logic        busy
);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  cmd_t            cmd_q, head, push_cmd;
  logic            full, empty, pop, to_hit, to_q;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  uart_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid & cmd_ready),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = ~full;
  assign pop       = (state_q == ST_IDLE) & ~empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    to_hit  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!empty) state_d = ST_REQ;
      ST_REQ: begin
        // a stale-high ready on entry counts as the acknowledge
        if (uart_ready) state_d = ST_REL;
        else if (cnt_q == TO_MAX) begin
          state_d = ST_RSP;
          to_hit  = 1'b1;
        end
      end
      ST_REL: begin
        if (!uart_ready) state_d = ST_RSP;
        else if (cnt_q == TO_MAX) begin
          state_d = ST_RSP;
          to_hit  = 1'b1;
        end
      end
      ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_RSP) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q   <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      if (pop) begin
        cmd_q   <= head;
        rdata_q <= '0;
        to_q    <= 1'b0;
      end
      if (state_q == ST_REQ && uart_ready && !cmd_q.write) rdata_q <= uart_reg_rdata;
      if (to_hit) begin
        to_q    <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  // enables decode straight from the state register so reset drops them at once
  assign uart_reg_wr_en = (state_q == ST_REQ) &  cmd_q.write;
  assign uart_reg_rd_en = (state_q == ST_REQ) & ~cmd_q.write;
  assign uart_reg_addr  = cmd_q.addr;
  assign uart_reg_wdata = cmd_q.wdata;
  assign rsp_valid      = (state_q == ST_RSP);
  assign rsp_write      = cmd_q.write;
  assign rsp_rdata      = rdata_q;
  assign rsp_timeout    = to_q;
  assign busy           = ~empty | (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: handshake timing, read capture,
// back-pressure ordering, timeouts and async reset.
module tb_uart_reg_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_timeout;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        uart_reg_wr_en, uart_reg_rd_en, busy;
  logic [31:0] uart_reg_addr, uart_reg_wdata;
  logic [31:0] uart_reg_rdata;
  logic        uart_ready;

  always #5 clk = ~clk;

  uart_reg_master #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .uart_reg_wr_en(uart_reg_wr_en), .uart_reg_rd_en(uart_reg_rd_en),
    .uart_reg_addr(uart_reg_addr), .uart_reg_wdata(uart_reg_wdata),
    .uart_reg_rdata(uart_reg_rdata), .uart_ready(uart_ready), .busy(busy)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // responder: acks ack_delay negedges after seeing an enable, keeps ready
  // high for hold extra cycles after the ack is taken
  bit          auto_ack = 1'b0;
  int          ack_delay = 2, hold = 0;
  logic [31:0] rd_val = '0;

  initial begin
    uart_ready = 1'b0;
    uart_reg_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_ack && (uart_reg_wr_en || uart_reg_rd_en)) begin
        repeat (ack_delay) @(negedge clk);
        uart_ready = 1'b1;
        uart_reg_rdata = rd_val;
        @(negedge clk);
        repeat (hold) @(negedge clk);
        uart_ready = 1'b0;
      end
    end
  end

  int en_cyc = 0;
  bit overlap = 1'b0;
  always @(negedge clk) begin
    if (uart_reg_wr_en || uart_reg_rd_en) en_cyc <= en_cyc + 1;
    if (uart_reg_wr_en && uart_reg_rd_en) overlap <= 1'b1;
  end

  // all tasks are entered at a negedge and return at a negedge
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("push_stall", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin @(negedge clk); n++; end
    if (!rsp_valid) chk("rsp_wait", 32'd0, 32'd1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int e0, n;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_en",        32'({uart_reg_wr_en, uart_reg_rd_en}), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_addr",      uart_reg_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // config write, ack 3 cycles into the request
    auto_ack = 1'b1; ack_delay = 2; hold = 0;
    e0 = en_cyc;
    push(1'b1, 32'h0, 32'h28E2001B);
    chk("cfg_lat0", 32'(uart_reg_wr_en), 32'd0);
    @(negedge clk);
    chk("cfg_lat1", 32'(uart_reg_wr_en), 32'd1);
    wait_rsp(100);
    chk("cfg_en_cycles", 32'(en_cyc - e0), 32'd3);
    chk("cfg_rsp_write", 32'(rsp_write), 32'd1);
    chk("cfg_rsp_to",    32'(rsp_timeout), 32'd0);
    chk("cfg_rsp_rdata", rsp_rdata, 32'd0);
    chk("cfg_wdata_hold", uart_reg_wdata, 32'h28E2001B);
    take_rsp();

    // read of data register
    rd_val = 32'h000000A5;
    push(1'b0, 32'h4, 32'h0);
    wait_rsp(100);
    chk("rd_rdata", rsp_rdata, 32'h000000A5);
    chk("rd_write", 32'(rsp_write), 32'd0);
    chk("rd_to",    32'(rsp_timeout), 32'd0);
    chk("rd_addr",  uart_reg_addr, 32'h4);
    chk("rd_overlap", 32'(overlap), 32'd0);
    take_rsp();

    // request-phase timeout, then a normal command
    auto_ack = 1'b0;
    e0 = en_cyc;
    push(1'b1, 32'h4, 32'h55);
    wait_rsp(100);
    chk("to_en_cycles", 32'(en_cyc - e0), 32'd16);
    chk("to_flag",  32'(rsp_timeout), 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    take_rsp();
    auto_ack = 1'b1; rd_val = 32'h3C;
    push(1'b0, 32'h8, 32'h0);
    wait_rsp(100);
    chk("after_to_rdata", rsp_rdata, 32'h3C);
    chk("after_to_flag",  32'(rsp_timeout), 32'd0);
    take_rsp();

    // ready stays high briefly after ack: wait for the fall
    ack_delay = 0; hold = 5;
    e0 = en_cyc;
    push(1'b1, 32'h0, 32'h11);
    wait_rsp(100);
    chk("short_en_cycles", 32'(en_cyc - e0), 32'd1);
    chk("short_to",        32'(rsp_timeout), 32'd0);
    chk("short_ready_low", 32'(uart_ready), 32'd0);
    take_rsp();

    // ready stuck high 50 cycles: release-phase timeout discards read data
    hold = 50; rd_val = 32'h77;
    push(1'b0, 32'h4, 32'h0);
    wait_rsp(100);
    chk("stuck_to",    32'(rsp_timeout), 32'd1);
    chk("stuck_rdata", rsp_rdata, 32'd0);
    chk("stuck_ready_high", 32'(uart_ready), 32'd1);
    take_rsp();
    n = 0;
    while (uart_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);

    // back-pressure: one in flight plus four queued
    auto_ack = 1'b0; hold = 0;
    for (int i = 0; i < 5; i++) push(1'b1, 32'h4, 32'(i));
    chk("bp_full", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    auto_ack = 1'b1; ack_delay = 1;
    for (int i = 0; i < 6; i++) begin
      wait_rsp(200);
      chk("bp_order", uart_reg_wdata, 32'(i));
      chk("bp_write", 32'(rsp_write), 32'd1);
      take_rsp();
      if (i == 0) push(1'b1, 32'h4, 32'd5);
    end

    // async reset while the request is held
    auto_ack = 1'b0;
    push(1'b1, 32'h0, 32'hAA);
    push(1'b1, 32'h4, 32'hBB);
    n = 0;
    while (!uart_reg_wr_en && n < 20) begin @(negedge clk); n++; end
    chk("rstmid_pre_en", 32'(uart_reg_wr_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_en",        32'({uart_reg_wr_en, uart_reg_rd_en}), 32'd0);
    chk("rstmid_busy",      32'(busy), 32'd0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_post_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_reg_master.md
Name: uart_reg_master

Overview:
Host-side initiator for the uart_top register bus. It accepts queued register commands (read or write, address, data) from a CPU-side valid/ready port and drives the uart_reg_* four-phase handshake. It returns one response per command: read data, or a write acknowledge, plus a timeout flag. It sits between the SoC interconnect and uart_top, replacing hand-sequenced enable/ready toggling.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 1024, max cycles waited per handshake phase before abort
TO_W, 11, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO not full; command accepted when valid&ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  32  register address (offset 0x00 config, 0x04 data, 0x08 status)
cmd_wdata  input  32  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when valid&ready
rsp_write  output  1  echo of cmd_write
rsp_rdata  output  32  read data (0 for writes and timeouts)
rsp_timeout  output  1  handshake aborted by timeout
uart_reg_wr_en  output  1  write request to uart_top
uart_reg_rd_en  output  1  read request to uart_top
uart_reg_addr  output  32  address to uart_top
uart_reg_wdata  output  32  write data to uart_top
uart_reg_rdata  input  32  read data from uart_top
uart_ready  input  1  uart_top acknowledge
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst=0, async): all outputs 0 except cmd_ready=1. FIFO emptied, FSM=IDLE, timeout counter=0.
- FIFO: push on cmd_valid&cmd_ready. cmd_ready=0 when CMD_DEPTH entries are held. Push while full is ignored. Simultaneous push and pop at full is not allowed; cmd_ready is registered from the occupancy count.
- FSM states: IDLE, REQ, REL, RSP.
- IDLE: if FIFO not empty, pop the head. Next edge: load addr/wdata, assert wr_en (write) or rd_en (read), go REQ. Command-to-enable latency is 1 cycle from the pop cycle, i.e. 2 cycles after push into an empty FIFO.
- REQ: enable held, addr/wdata stable. On the first cycle uart_ready=1 (synchronous sample):
  - capture uart_reg_rdata (reads only),
  - deassert the enable on the next edge,
  - go REL.
- REL: enable=0. Wait for uart_ready=0, then go RSP.
- RSP: rsp_valid=1 and all rsp_* held stable until rsp_ready=1. Then go IDLE the next edge; the next command may start from IDLE the following cycle.
- Timeout:
  - The counter clears on each state entry and increments in REQ and REL.
  - Reaching TIMEOUT_CYCLES-1 forces enables to 0, sets rsp_timeout=1 with rsp_rdata=0, and goes RSP.
  - A REQ timeout does not wait for uart_ready to fall.
- uart_ready already high on entry to REQ (stale acknowledge): treat it as the acknowledge. There is no extra wait.
- wr_en and rd_en are never both 1. uart_reg_addr/uart_reg_wdata are held after the transaction; only the enables return to 0.
- Reset mid-transaction: enables drop immediately (async). Queued commands and any pending response are discarded.
- Only one transaction is outstanding toward uart_top at a time. Responses are returned in command order.

Decomposition:
- Shared package (uart_pkg): register offsets (UART_REG_CFG=0x00, UART_REG_DATA=0x04, UART_REG_STAT=0x08), FSM state encodings, and config-word field positions (divisor [15:0], [20:16], [24:21], parity [26:25], stop [28:27], rx int enable [29]).
- One sub-module: uart_cmd_fifo (synchronous FIFO, 65-bit entries {write, addr, wdata}, CMD_DEPTH deep, full/empty flags).

Test Plan:
- Config write: push write 0x00 / 0x28E2001B; responder raises uart_ready 3 cycles after wr_en -> wr_en high exactly until the edge after uart_ready; rsp_valid with rsp_write=1, rsp_timeout=0.
- Read: push read 0x04; responder returns rdata 0x000000A5 with uart_ready -> rsp_rdata=0x000000A5, rd_en never overlaps wr_en.
- Back-pressure: push 6 writes (data 0..5) with rsp_ready=0 and a responder that never acks -> cmd_ready falls after 4 queued; after the responder is released, 6 responses arrive in order.
- Timeout: responder never asserts uart_ready, TIMEOUT_CYCLES=16 -> wr_en drops after 16 cycles; rsp_timeout=1, rsp_rdata=0; the next command proceeds normally.
- Stuck-high release: uart_ready held high 50 cycles after the ack -> FSM stays in REL; a response is produced only after uart_ready falls, or with rsp_timeout=1 if 50 >= TIMEOUT_CYCLES.
- Reset in REQ: assert rst=0 mid-handshake -> enables 0 within the same cycle (async), busy=0, rsp_valid=0, cmd_ready=1.
